keyvalue_store: RTL
===================

Name: keyvalue_store

Overview:
- Parametrised successor to the single-bit key/value block.
- Associative store of DEPTH entries, each holding a KEY_W-bit key and a VAL_W-bit value.
- Controlled through a 32-bit Wishbone slave register window; a sequential scan FSM executes PUT/GET/DEL/CLEAR commands.
- Sits behind the project wrapper; status goes to the logic analyser and the last GET result goes to the IO pads.

Parameters:
- KEY_W, 16: key width, 1..32.
- VAL_W, 16: value width, 1..32.
- DEPTH, 8: number of entries, power of two, 2..64.
- IO_W, 38: width of BUF_o (MPRJ_IO_PADS).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- STB_i  in  1  Wishbone strobe.
- CYC_i  in  1  Wishbone cycle.
- WE_i  in  1  Wishbone write enable.
- DAT_i  in  32  Wishbone write data.
- ADR_i  in  32  Wishbone address; only ADR_i[3:2] is decoded.
- ACK_o  out  1  Wishbone acknowledge.
- DAT_o  out  32  Wishbone read data.
- LA_o  out  32  logic-analyser status word.
- BUF_o  out  IO_W  IO pad data.

Behaviour:
- Reset (sync sys_rst): all valid bits cleared, count=0, KEY=0, VAL=0, RESULT=0, hit=0, err=0, FSM=IDLE, ACK_o=0, DAT_o=0, LA_o=0, BUF_o=0.
- Reset mid-scan aborts the command; no entry is modified.
- Bus access (request = STB_i&CYC_i&!ACK_o seen at cycle T):
  - ACK_o=1 at T+1 for exactly one cycle. DAT_o is valid with ACK_o and is 0 otherwise.
  - Back-to-back requests give ACK every other cycle.
- Register map (ADR_i[3:2]):
  - 0 KEY (RW): low KEY_W bits; reads are zero-extended.
  - 1 VAL (W = value operand, R = RESULT).
  - 2 CMD (W; reads 0): DAT_i[1:0] selects 0=CLEAR, 1=PUT, 2=GET, 3=DEL.
  - 3 STATUS (R; writes ignored): bit0 busy, bit1 hit, bit2 err, bit3 full, bits[14:8] count.
- Busy rule: KEY/VAL/CMD writes while busy are acked but ignored, and a CMD write while busy sets err. Otherwise err is cleared by every accepted CMD.
- FSM states IDLE, SCAN, COMMIT:
  - IDLE: an accepted CMD at T latches the opcode, clears hit, sets busy at T+1. CLEAR goes to COMMIT; other opcodes go to SCAN with idx=0.
  - SCAN: one entry per cycle, entry k examined at T+1+k.
    - Tracks the lowest-index free slot.
    - match = valid[k] && key[k]==KEY.
    - On match, or when k==DEPTH-1, go to COMMIT.
  - COMMIT (one cycle), then IDLE with busy=0:
    - PUT hit: overwrite value; hit=1.
    - PUT miss with a free slot: write key/value to the lowest free index; count+1.
    - PUT miss while full: err=1, no change.
    - GET hit: RESULT=value, hit=1. GET miss: RESULT=0.
    - DEL hit: clear valid, count-1, hit=1. DEL miss: no change.
    - CLEAR: all valid=0, count=0.
- Latency:
  - Match at index k: busy falls at T+3+k.
  - Miss: busy falls at T+2+DEPTH.
  - CLEAR: busy falls at T+2.
- Invariants:
  - full = (count==DEPTH).
  - count is $clog2(DEPTH)+1 bits and never wraps.
  - Keys are unique; a duplicate PUT overwrites.
- LA_o = {16'b0, count zero-extended to 8 bits, 2'b0, state[1:0], full, err, hit, busy}.
- BUF_o = RESULT zero-extended to IO_W, updated in COMMIT of GET only.

Test Plan:
- Reset, then read STATUS → 0x0000, ACK exactly 1 cycle after STB; read VAL → 0.
- KEY=0x0012, VAL=0xBEEF, CMD=PUT; poll busy → busy 1 for DEPTH+1 cycles. GET 0x0012 → RESULT=0xBEEF, hit=1, count=1, BUF_o[15:0]=0xBEEF, match at k=0 (busy falls at T+3).
- Fill 8 distinct keys, then PUT a 9th → err=1, full=1, count=8. PUT an existing key with VAL=0x1234 → hit=1, GET returns 0x1234, count stays 8.
- DEL key in slot 3, then PUT a new key → the new key lands in slot 3 (a GET of it matches at k=3), count back to 8. DEL a missing key → hit=0, count unchanged.
- CMD write while busy → acked, ignored, err=1; the first command completes correctly. CLEAR → count=0 two cycles later, all GETs miss.
- Assert sys_rst during SCAN of a PUT → after reset count=0, no entry written, ACK_o=0, FSM IDLE.

Source files
------------

// File: rtl/keyvalue_store.sv
// Associative key/value store behind a 32-bit Wishbone register window.
// A sequential scan FSM walks the entries one per cycle to execute PUT/GET/DEL/CLEAR.
module keyvalue_store #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16,
    parameter int DEPTH = 8,
    parameter int IO_W  = 38
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            STB_i,
    input  logic            CYC_i,
    input  logic            WE_i,
    input  logic [31:0]     DAT_i,
    input  logic [31:0]     ADR_i,
    output logic            ACK_o,
    output logic [31:0]     DAT_o,
    output logic [31:0]     LA_o,
    output logic [IO_W-1:0] BUF_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_PUT   = 2'd1,
        OP_GET   = 2'd2,
        OP_DEL   = 2'd3
    } op_t;

    localparam logic [1:0] REG_KEY    = 2'd0;
    localparam logic [1:0] REG_VAL    = 2'd1;
    localparam logic [1:0] REG_CMD    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    state_t           state, state_next;
    op_t              op;
    logic [KEY_W-1:0] key_reg;
    logic [VAL_W-1:0] val_reg;
    logic [VAL_W-1:0] result;
    logic             hit, err;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] valid;
    logic [IW-1:0]    idx, match_idx, free_idx;
    logic             match_found, free_found;

    logic [KEY_W-1:0] keys [DEPTH];
    logic [VAL_W-1:0] vals [DEPTH];

    logic        req, wr, rd, busy, full, cmd_wr, cmd_accept, match, last;
    logic [1:0]  reg_sel;
    logic [31:0] rdata;

    // A request is only taken while ACK is low, so a held strobe acks every other cycle.
    assign req        = STB_i & CYC_i & ~ACK_o;
    assign wr         = req & WE_i;
    assign rd         = req & ~WE_i;
    assign reg_sel    = ADR_i[3:2];
    assign busy       = (state != IDLE);
    assign full       = (count == CW'(DEPTH));
    assign cmd_wr     = wr && (reg_sel == REG_CMD);
    assign cmd_accept = cmd_wr && !busy;
    assign match      = (state == SCAN) && valid[idx] && (keys[idx] == key_reg);
    assign last       = (idx == IW'(DEPTH - 1));

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path through the block leaves a value held (which would infer a latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_accept) state_next = (DAT_i[1:0] == OP_CLEAR) ? COMMIT : SCAN;
            SCAN:    if (match || last) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_KEY:    rdata = 32'(key_reg);
            REG_VAL:    rdata = 32'(result);
            REG_CMD:    rdata = '0;
            REG_STATUS: rdata = {17'b0, 7'(count), 4'b0, full, err, hit, busy};
            default:    rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            op          <= OP_CLEAR;
            key_reg     <= '0;
            val_reg     <= '0;
            result      <= '0;
            hit         <= 1'b0;
            err         <= 1'b0;
            count       <= '0;
            valid       <= '0;
            idx         <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            ACK_o       <= 1'b0;
            DAT_o       <= '0;
        end else begin
            state <= state_next;
            ACK_o <= req;
            DAT_o <= rd ? rdata : '0;

            // Operands are frozen while a command runs.
            if (wr && !busy) begin
                if (reg_sel == REG_KEY) key_reg <= DAT_i[KEY_W-1:0];
                if (reg_sel == REG_VAL) val_reg <= DAT_i[VAL_W-1:0];
            end
            if (cmd_wr && busy) err <= 1'b1;

            if (cmd_accept) begin
                op          <= op_t'(DAT_i[1:0]);
                hit         <= 1'b0;
                err         <= 1'b0;
                idx         <= '0;
                match_found <= 1'b0;
                free_found  <= 1'b0;
            end

            case (state)
                SCAN: begin
                    idx <= idx + IW'(1);
                    if (!valid[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (match) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                end
                COMMIT: begin
                    case (op)
                        OP_CLEAR: begin
                            valid <= '0;
                            count <= '0;
                        end
                        OP_PUT: begin
                            if (match_found) begin
                                hit <= 1'b1;
                            end else if (free_found) begin
                                valid[free_idx] <= 1'b1;
                                count           <= count + CW'(1);
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        OP_GET: begin
                            if (match_found) begin
                                result <= vals[match_idx];
                                hit    <= 1'b1;
                            end else begin
                                result <= '0;
                            end
                        end
                        OP_DEL: begin
                            if (match_found) begin
                                valid[match_idx] <= 1'b0;
                                count            <= count - CW'(1);
                                hit              <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // NOTE: the key/value arrays carry no reset; an entry is meaningless until its
    // valid bit is set, and leaving reset off lets the arrays map onto RAM.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && state == COMMIT && op == OP_PUT) begin
            if (match_found) begin
                vals[match_idx] <= val_reg;
            end else if (free_found) begin
                keys[free_idx] <= key_reg;
                vals[free_idx] <= val_reg;
            end
        end
    end

    assign LA_o = {16'b0, 8'(count), 2'b0, state, full, err, hit, busy};

    generate
        if (IO_W > VAL_W) begin : g_buf_pad
            assign BUF_o = {{(IO_W - VAL_W){1'b0}}, result};
        end else begin : g_buf_trunc
            assign BUF_o = result[IO_W-1:0];
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{ADR_i[31:4], ADR_i[1:0], DAT_i};

endmodule
